// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        filled;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch entries: allocated at request accept, filled by
// in-order memory responses, popped by decode, cleared wholesale on flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alloc,
  input  logic [31:0]  alloc_pc,
  input  logic         fill,
  input  logic [31:0]  fill_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] occ,
  output logic [CW-1:0] unfilled
);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] fill_ptr;

  // Alloc, fill and pop never touch the same slot in one cycle: alloc needs a
  // free tail slot, fill targets an unfilled entry, pop a filled one.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      occ      <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        entries[tail_ptr] <= '{pc: alloc_pc, data: 32'h0, filled: 1'b0};
        tail_ptr          <= tail_ptr + 1'b1;
      end
      if (fill) begin
        entries[fill_ptr].data   <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + 1'b1;
      end
      if (pop) begin
        entries[head_ptr].filled <= 1'b0;
        head_ptr                 <= head_ptr + 1'b1;
      end
      occ      <= occ + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

  assign head = entries[head_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues in-order memory requests, tags
// returned words with their PC and discards responses made stale by redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] fetch_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_entry_t  head;
  logic [CW-1:0] occ;
  logic [CW-1:0] unfilled;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   inflight;
  logic          accept;
  logic          fill;
  logic          pop;
  logic          drop_resp;
  logic          resp_taken;

  always_comb begin
    inflight       = {1'b0, occ} + {1'b0, drop_cnt};
    imem_req_valid = !reset && !redirect_valid && (inflight < (CW+1)'(BUF_DEPTH));
    accept         = imem_req_valid && imem_req_ready;
    drop_resp      = imem_resp_valid && (drop_cnt != '0);
    fill           = imem_resp_valid && (drop_cnt == '0) && (unfilled != '0) && !redirect_valid;
    pop            = head.filled && instr_ready && !redirect_valid;
    resp_taken     = imem_resp_valid && ((drop_cnt != '0) || (unfilled != '0));
  end

  // A response arriving with a redirect belongs to the old stream: it either
  // retires one pending drop or the oldest unfilled entry, so it never adds to
  // the number of words still to be discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      drop_cnt <= drop_cnt + unfilled - CW'(resp_taken);
      fetch_pc <= redirect_target & INSTR_ALIGN_MASK;
    end else begin
      if (drop_resp) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH(BUF_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .alloc    (accept),
    .alloc_pc (fetch_pc),
    .fill     (fill),
    .fill_data(imem_resp_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .occ      (occ),
    .unfilled (unfilled)
  );

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = head.filled;
  assign instr         = head.data;
  assign instr_pc      = head.pc;

  // A response with nothing pending and nothing to drop is a memory protocol error.
  a_resp_expected: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> ((drop_cnt != '0) || (unfilled != '0)));

  a_drop_bound: assert property (@(posedge clk) disable iff (reset)
    drop_cnt <= CW'(BUF_DEPTH));

endmodule
